shift_collector: RTL
====================

SHIFT_COLLECTOR -- requirements
Module: shift_collector

Interface
REQ-001 SHALL have parameter DW, default `DATASIZE: element width; one serial word is 2*DW bits.
REQ-002 SHALL have parameter DEPTH, default `ARRAYHEIGHT: serial words per frame, DEPTH >= 2.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous, active-low.
REQ-005 SHALL have port clear  input  1: synchronous discard of the current frame.
REQ-006 SHALL have port in_valid  input  1: serial word present on in.
REQ-007 SHALL have port in  input  2*DW: serial word from the array output side.
REQ-008 SHALL have port in_ready  output  1: collector accepts in this cycle.
REQ-009 SHALL have port out_valid  output  1: full frame present on out.
REQ-010 SHALL have port out_ready  input  1: downstream takes the frame.
REQ-011 SHALL have port out  output  2*DEPTH*DW: assembled parallel frame.
REQ-012 SHALL have port count  output  $clog2(DEPTH+1): words held in the current frame.
REQ-013 SHALL have port overflow  output  1: sticky flag for a word dropped while full.

Function
REQ-014 SHALL implement states IDLE (count=0), FILL (0<count<DEPTH) and HOLD (count=DEPTH, out_valid=1).
REQ-015 SHALL accept a word when in_valid && in_ready; in_ready = (state!=HOLD) || out_ready.
REQ-016 SHALL shift each accepted word in at the top: mem <= {in, mem[2*DEPTH*DW-1:2*DW]}; after DEPTH accepts, the first word is in out[2*DW-1:0] and the last is in the top slice.
REQ-017 SHALL transition IDLE->FILL on accept, FILL->FILL on accept while count<DEPTH-1, and FILL->HOLD on the accept that makes count=DEPTH; no transition when there is no accept.
REQ-018 SHALL assert out_valid in the cycle after the DEPTH-th accept, giving a latency of 1 cycle from the last word to the frame.
REQ-019 SHALL hold out and out_valid stable in HOLD until out_ready=1, with the frame completing on out_valid && out_ready.
REQ-020 SHALL, on HOLD with out_ready=1 and no accept, go to IDLE with count=0 and mem cleared to 0.
REQ-021 SHALL, on HOLD with out_ready=1 and a simultaneous accept, go to FILL with count=1, the new word in the top slice and all other slices 0.
REQ-022 SHALL drive out=0 whenever out_valid=0.
REQ-023 SHALL, when in_valid=1 and in_ready=0, drop the word, set overflow=1, and leave mem and count unchanged.
REQ-024 SHALL keep overflow set until reset or clear.
REQ-025 SHALL give clear=1 priority over every other event: next state IDLE, count=0, mem=0, out_valid=0, overflow=0; any in word and any frame on out that cycle are discarded and no transfer counts.
REQ-026 SHALL drive count with the registered number of words held, taking values 0..DEPTH.

Reset
REQ-027 SHALL, while rst=0 at a rising edge, force state IDLE, mem=0, count=0, out_valid=0 and overflow=0; in_ready=1 in the cycle after reset.
REQ-028 SHALL give rst=0 priority over clear and all handshakes.
REQ-029 SHALL abandon a partial or held frame on reset mid-operation; the first frame after reset starts from an empty collector.

Verification (DW=8, DEPTH=4)
REQ-030 SHALL cover basic fill: reset, then words 0x0001,0x0002,0x0003,0x0004 on consecutive cycles with out_ready=0 -> next cycle out_valid=1, out=0x0004_0003_0002_0001, count=4, in_ready=0.
REQ-031 SHALL cover backpressure: hold the frame for 5 cycles with out_ready=0 -> out stable, then out_ready=1 for one cycle -> state IDLE, count=0, out=0.
REQ-032 SHALL cover back-to-back transfer: in HOLD, out_ready=1 with in_valid=1, in=0x00AA -> frame transfers, count=1, next frame completes after 3 more words.
REQ-033 SHALL cover overflow: in HOLD, out_ready=0, in_valid=1, in=0x00FF -> word dropped, overflow=1, out unchanged; then clear=1 -> overflow=0, count=0, out_valid=0.
REQ-034 SHALL cover gapped input: words at cycles 0,3,4,9 -> out_valid rises at cycle 10; count steps 1,2,3,4.
REQ-035 SHALL cover reset mid-frame: after 2 words, rst=0 for one cycle -> count=0; 4 new words give a frame containing only the new words.

Source files
------------

// File: rtl/shift_collector.sv
// Serial-to-parallel collector: gathers DEPTH serial words of 2*DW bits into one
// parallel frame and holds it under valid/ready handshake until downstream takes it.
`ifndef DATASIZE
`define DATASIZE 8
`endif
`ifndef ARRAYHEIGHT
`define ARRAYHEIGHT 4
`endif

module shift_collector #(
  parameter int DW    = `DATASIZE,
  parameter int DEPTH = `ARRAYHEIGHT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         in_valid,
  input  logic [2*DW-1:0]              in,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [2*DEPTH*DW-1:0]        out,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic [1:0]                   o_state
);

  localparam int WW = 2 * DW;
  localparam int FW = 2 * DEPTH * DW;
  localparam int CW = $clog2(DEPTH + 1);

  // Handshakes: a word moves on in_valid && in_ready, a frame moves on
  // out_valid && out_ready. Neither side may retract valid before the transfer;
  // clear cancels both transfers in the cycle it is high.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [FW-1:0]   r_mem;
  logic [CW-1:0]   r_count;
  logic            r_overflow;
  logic            w_accept;
  logic            w_xfer;

  assign w_accept = in_valid && in_ready && !clear;
  assign w_xfer   = out_valid && out_ready && !clear;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (clear) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) w_next_state = S_FILL;
        S_FILL: if (w_accept && (r_count == CW'(DEPTH - 1))) w_next_state = S_HOLD;
        S_HOLD: if (out_ready) w_next_state = w_accept ? S_FILL : S_IDLE;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    out_valid = (r_state == S_HOLD);
    in_ready  = (r_state != S_HOLD) || out_ready;
    out       = out_valid ? r_mem : '0;
    o_state   = r_state;
  end

  // A frame leaving in the same cycle as a new word restarts the shift register
  // with only that word, so stale slices never reach the next frame.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      r_mem      <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_mem   <= w_accept ? {in, {(FW - WW){1'b0}}} : '0;
        r_count <= w_accept ? CW'(1) : '0;
      end else if (w_accept) begin
        r_mem   <= {in, r_mem[FW-1:WW]};
        r_count <= r_count + CW'(1);
      end
      if (in_valid && !in_ready) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign count    = r_count;
  assign overflow = r_overflow;

endmodule
